// File: rtl/pistorm_pkg.sv
// Shared definitions for the PiStorm host front end: register selects,
// transaction FSM states, idle function code and status readback layout.
package pistorm_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_ADDR_LO = 2'd1;
  localparam logic [1:0] REG_ADDR_HI = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2,
    ST_ACTIVE  = 2'd3
  } txn_state_e;

  localparam logic [2:0] FC_IDLE = 3'b111;

  // Status readback word layout
  localparam int STAT_BERR_BIT    = 0;
  localparam int STAT_OVERRUN_BIT = 1;
  localparam int STAT_IPL_LSB     = 13;

  // Assemble the STATUS readback word from its fields.
  function automatic logic [15:0] status_word(input logic [2:0] ipl,
                                              input logic overrun,
                                              input logic berr_seen);
    logic [15:0] w;
    w = '0;
    w[STAT_IPL_LSB +: 3]  = ipl;
    w[STAT_OVERRUN_BIT]   = overrun;
    w[STAT_BERR_BIT]      = berr_seen;
    return w;
  endfunction

endpackage

// File: rtl/pi_strobe_sync.sv
// Synchroniser for an asynchronous Pi GPIO strobe: a SYNC_STAGES flop
// chain producing the synchronised level and a one-cycle rising-edge pulse.
module pi_strobe_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw strobe through the chain; bit 0 is the metastable stage.
  always_ff @(posedge clk) begin
    if (!reset_n) chain <= '0;
    else          chain <= {chain[SYNC_STAGES-2:0], strobe};
  end

  // Edge is seen while the new 1 sits just before a last stage still at 0.
  assign level = chain[SYNC_STAGES-1];
  assign rise  = chain[SYNC_STAGES-2] & ~chain[SYNC_STAGES-1];

endmodule

// File: rtl/pi_host_frontend.sv
// PiStorm host register front end: synchronises Pi strobes, decodes the
// DATA/ADDR_LO/ADDR_HI/STATUS registers into a bus-cycle command with a
// valid/ready handshake, and owns status, bus-error and IPL readback.
// Optional feature macro: PISTORM_IPL_FILTER_EN (two-sample IPL glitch filter).
module pi_host_frontend
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        c200m,
  input  logic        reset_n,
  input  logic [1:0]  pi_a,
  input  logic        pi_rd,
  input  logic        pi_wr,
  input  logic [15:0] pi_d_in,
  output logic [15:0] pi_d_out,
  output logic        pi_d_oe,
  output logic        pi_txn_in_progress,
  output logic        pi_ipl_zero,
  input  logic        c7m_falling,
  input  logic [2:0]  m68k_ipl_n,
  input  logic        m68k_berr_n,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_rw,
  output logic        cmd_uds_n,
  output logic        cmd_lds_n,
  output logic [2:0]  cmd_fc,
  input  logic        cmd_done,
  output logic [15:0] status_q,
  output logic        reset_out
);

  logic       rd_level, rd_rise;
  logic       wr_level, wr_rise;
  logic       unused_levels;

  txn_state_e state, state_next;
  logic       valid_next;
  logic       a0;
  logic       overrun, berr_seen;
  logic [2:0] ipl, ipl_1;

  logic       lo_wr, hi_wr, status_wr, status_rd;
  logic       addr_open, overrun_evt;

  pi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .clk     (c200m),
    .reset_n (reset_n),
    .strobe  (pi_rd),
    .level   (rd_level),
    .rise    (rd_rise)
  );

  pi_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .clk     (c200m),
    .reset_n (reset_n),
    .strobe  (pi_wr),
    .level   (wr_level),
    .rise    (wr_rise)
  );

  // Only the edge pulses drive behaviour; levels are kept for observability.
  assign unused_levels = rd_level ^ wr_level;

  // pi_a is held stable by the Pi while its strobe is high, so it is safe
  // to decode it in the edge-detect cycle.
  assign lo_wr       = wr_rise && (pi_a == REG_ADDR_LO);
  assign hi_wr       = wr_rise && (pi_a == REG_ADDR_HI);
  assign status_wr   = wr_rise && (pi_a == REG_STATUS);
  assign status_rd   = rd_rise && (pi_a == REG_STATUS);
  assign addr_open   = (state == ST_IDLE) || (state == ST_ARMED);
  assign overrun_evt = (lo_wr || hi_wr) && !addr_open;

  assign pi_d_oe            = (pi_a == REG_STATUS) && pi_rd;
  assign pi_txn_in_progress = (state != ST_IDLE);
  assign reset_out          = !status_q[1];

  // Transaction state register.
  always_ff @(posedge c200m) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cmd_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_valid <= valid_next;
    end
  end

  // Next-state logic; cmd_valid is offered from the cycle after PENDING is
  // entered and withdrawn in the cycle after the handshake.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lo_wr)      state_next = ST_ARMED;
        else if (hi_wr) state_next = ST_PENDING;
      end
      ST_ARMED: begin
        if (hi_wr) state_next = ST_PENDING;
      end
      ST_PENDING: begin
        if (cmd_valid && cmd_ready) state_next = ST_ACTIVE;
        else                        valid_next = 1'b1;
      end
      ST_ACTIVE: begin
        if (cmd_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Command fields: only loaded while no command is outstanding.
  always_ff @(posedge c200m) begin
    if (!reset_n) begin
      a0        <= 1'b0;
      cmd_rw    <= 1'b1;
      cmd_uds_n <= 1'b1;
      cmd_lds_n <= 1'b1;
      cmd_fc    <= FC_IDLE;
    end else if (addr_open) begin
      if (lo_wr) a0 <= pi_d_in[0];
      if (hi_wr) begin
        cmd_rw <= pi_d_in[9];
        cmd_fc <= pi_d_in[15:13];
        if (pi_d_in[8]) begin
          cmd_uds_n <= a0;
          cmd_lds_n <= !a0;
        end else begin
          cmd_uds_n <= 1'b0;
          cmd_lds_n <= 1'b0;
        end
      end
    end
  end

  // STATUS register, sticky flags and readback capture; a new event in
  // the capture cycle survives the read-clear.
  always_ff @(posedge c200m) begin
    if (!reset_n) begin
      status_q  <= '0;
      pi_d_out  <= '0;
      overrun   <= 1'b0;
      berr_seen <= 1'b0;
    end else begin
      if (status_wr) status_q <= pi_d_in;
      if (status_rd) pi_d_out <= status_word(ipl, overrun, berr_seen);
      overrun   <= (overrun   && !status_rd) || overrun_evt;
      berr_seen <= (berr_seen && !status_rd) || !m68k_berr_n;
    end
  end

`ifdef PISTORM_IPL_FILTER_EN
  logic [2:0] ipl_2;

  // IPL sampled on the 7 MHz falling edge; only a value seen on two
  // consecutive samples is accepted.
  always_ff @(posedge c200m) begin
    if (!reset_n) begin
      ipl_1 <= '0;
      ipl_2 <= '0;
      ipl   <= '0;
    end else begin
      if (c7m_falling) begin
        ipl_1 <= ~m68k_ipl_n;
        ipl_2 <= ipl_1;
      end
      if (ipl_2 == ipl_1) ipl <= ipl_2;
    end
  end
`else
  // IPL sampled on the 7 MHz falling edge and passed through unfiltered.
  always_ff @(posedge c200m) begin
    if (!reset_n) begin
      ipl_1 <= '0;
      ipl   <= '0;
    end else begin
      if (c7m_falling) ipl_1 <= ~m68k_ipl_n;
      ipl <= ipl_1;
    end
  end
`endif

  // Registered zero-IPL flag for the Pi.
  always_ff @(posedge c200m) begin
    if (!reset_n) pi_ipl_zero <= 1'b0;
    else          pi_ipl_zero <= (ipl == 3'd0);
  end

endmodule

// File: tb/tb_pi_host_frontend.sv
// Directed bench for pi_host_frontend: table of command decodes plus
// hand-written stall, overrun, bus-error, IPL and reset sequences.
module tb_pi_host_frontend;
  import pistorm_pkg::*;

  localparam int SYNC = 2;

  logic        c200m;
  logic        reset_n;
  logic [1:0]  pi_a;
  logic        pi_rd, pi_wr;
  logic [15:0] pi_d_in;
  logic [15:0] pi_d_out;
  logic        pi_d_oe;
  logic        pi_txn_in_progress;
  logic        pi_ipl_zero;
  logic        c7m_falling;
  logic [2:0]  m68k_ipl_n;
  logic        m68k_berr_n;
  logic        cmd_valid, cmd_ready;
  logic        cmd_rw, cmd_uds_n, cmd_lds_n;
  logic [2:0]  cmd_fc;
  logic        cmd_done;
  logic [15:0] status_q;
  logic        reset_out;

  int n_vec  = 0;
  int n_fail = 0;

  pi_host_frontend #(.SYNC_STAGES(SYNC)) dut (
    .c200m              (c200m),
    .reset_n            (reset_n),
    .pi_a               (pi_a),
    .pi_rd              (pi_rd),
    .pi_wr              (pi_wr),
    .pi_d_in            (pi_d_in),
    .pi_d_out           (pi_d_out),
    .pi_d_oe            (pi_d_oe),
    .pi_txn_in_progress (pi_txn_in_progress),
    .pi_ipl_zero        (pi_ipl_zero),
    .c7m_falling        (c7m_falling),
    .m68k_ipl_n         (m68k_ipl_n),
    .m68k_berr_n        (m68k_berr_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_rw             (cmd_rw),
    .cmd_uds_n          (cmd_uds_n),
    .cmd_lds_n          (cmd_lds_n),
    .cmd_fc             (cmd_fc),
    .cmd_done           (cmd_done),
    .status_q           (status_q),
    .reset_out          (reset_out)
  );

  initial c200m = 1'b0;
  always #5 c200m = ~c200m;

  typedef struct {
    logic        do_lo;
    logic [15:0] lo_d;
    logic [15:0] hi_d;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [2:0]  fc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, req);
    end
  endtask

  task automatic pi_write(input logic [1:0] a, input logic [15:0] d);
    pi_a    = a;
    pi_d_in = d;
    pi_wr   = 1'b1;
    repeat (SYNC + 3) @(negedge c200m);
    pi_wr = 1'b0;
    repeat (SYNC + 1) @(negedge c200m);
  endtask

  task automatic pi_read(output logic [15:0] val);
    pi_a  = REG_STATUS;
    pi_rd = 1'b1;
    repeat (SYNC + 3) @(negedge c200m);
    check("pi_d_oe", {15'd0, pi_d_oe}, 16'd1);
    val   = pi_d_out;
    pi_rd = 1'b0;
    repeat (SYNC + 1) @(negedge c200m);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!cmd_valid && n < 50) begin
      @(negedge c200m);
      n++;
    end
    check("cmd_valid_rise", {15'd0, cmd_valid}, 16'd1);
  endtask

  task automatic check_fields(input string tag, input logic rw, input logic uds,
                              input logic lds, input logic [2:0] fc);
    check({tag, ".rw"},    {15'd0, cmd_rw},    {15'd0, rw});
    check({tag, ".uds_n"}, {15'd0, cmd_uds_n}, {15'd0, uds});
    check({tag, ".lds_n"}, {15'd0, cmd_lds_n}, {15'd0, lds});
    check({tag, ".fc"},    {13'd0, cmd_fc},    {13'd0, fc});
  endtask

  task automatic handshake_and_done();
    cmd_ready = 1'b1;
    @(negedge c200m);
    cmd_ready = 1'b0;
    check("valid_drop_after_accept", {15'd0, cmd_valid}, 16'd0);
    check("txn_busy_active", {15'd0, pi_txn_in_progress}, 16'd1);
    repeat (3) @(negedge c200m);
    cmd_done = 1'b1;
    @(negedge c200m);
    cmd_done = 1'b0;
    check("txn_clear_after_done", {15'd0, pi_txn_in_progress}, 16'd0);
  endtask

  task automatic pulse_c7m();
    c7m_falling = 1'b1;
    @(negedge c200m);
    c7m_falling = 1'b0;
    repeat (3) @(negedge c200m);
  endtask

  logic [15:0] rv;

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 16'hA300, 1'b1, 1'b1, 1'b0, 3'b101};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[2] = '{1'b1, 16'h0000, 16'h4100, 1'b0, 1'b0, 1'b1, 3'b010};
    vecs[3] = '{1'b0, 16'h0000, 16'hE300, 1'b1, 1'b0, 1'b1, 3'b111};
    vecs[4] = '{1'b1, 16'h0003, 16'h2200, 1'b1, 1'b0, 1'b0, 3'b001};
    vecs[5] = '{1'b0, 16'h0000, 16'h6100, 1'b0, 1'b1, 1'b0, 3'b011};

    reset_n = 1'b0; pi_a = REG_DATA; pi_rd = 1'b0; pi_wr = 1'b0; pi_d_in = '0;
    c7m_falling = 1'b0; m68k_ipl_n = 3'b111; m68k_berr_n = 1'b1;
    cmd_ready = 1'b0; cmd_done = 1'b0;
    repeat (3) @(negedge c200m);

    // Reset values
    check("rst.cmd_valid", {15'd0, cmd_valid}, 16'd0);
    check_fields("rst", 1'b1, 1'b1, 1'b1, 3'b111);
    check("rst.txn", {15'd0, pi_txn_in_progress}, 16'd0);
    check("rst.ipl_zero", {15'd0, pi_ipl_zero}, 16'd0);
    check("rst.pi_d_out", pi_d_out, 16'h0000);
    check("rst.status_q", status_q, 16'h0000);
    check("rst.reset_out", {15'd0, reset_out}, 16'd1);
    check("rst.d_oe_idle", {15'd0, pi_d_oe}, 16'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge c200m);
    check("ipl_zero_after_rst", {15'd0, pi_ipl_zero}, 16'd1);

    // Command decode table
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_lo) begin
        pi_write(REG_ADDR_LO, vecs[i].lo_d);
        check($sformatf("v%0d.armed_txn", i), {15'd0, pi_txn_in_progress}, 16'd1);
        check($sformatf("v%0d.armed_novalid", i), {15'd0, cmd_valid}, 16'd0);
      end
      pi_write(REG_ADDR_HI, vecs[i].hi_d);
      wait_valid();
      check($sformatf("v%0d.txn", i), {15'd0, pi_txn_in_progress}, 16'd1);
      check_fields($sformatf("v%0d", i), vecs[i].rw, vecs[i].uds_n, vecs[i].lds_n, vecs[i].fc);
      handshake_and_done();
    end

    // Word write stalled 20 cycles; a stray done in PENDING is ignored
    pi_write(REG_ADDR_HI, 16'h0000);
    wait_valid();
    for (int c = 0; c < 20; c++) begin
      cmd_done = (c == 10);
      check("stall.valid", {15'd0, cmd_valid}, 16'd1);
      check_fields("stall", 1'b0, 1'b0, 1'b0, 3'b000);
      @(negedge c200m);
    end
    cmd_done = 1'b0;
    check("stall.valid_end", {15'd0, cmd_valid}, 16'd1);
    handshake_and_done();

    // Overrun: address writes while ACTIVE are ignored and flagged
    pi_write(REG_ADDR_HI, 16'hA300);
    wait_valid();
    cmd_ready = 1'b1;
    @(negedge c200m);
    cmd_ready = 1'b0;
    pi_write(REG_ADDR_HI, 16'h0000);
    check_fields("ovr", 1'b1, 1'b1, 1'b0, 3'b101);
    check("ovr.novalid", {15'd0, cmd_valid}, 16'd0);
    cmd_done = 1'b1;
    @(negedge c200m);
    cmd_done = 1'b0;
    pi_read(rv);
    check("ovr.read1", rv, 16'h0002);
    pi_read(rv);
    check("ovr.read2", rv, 16'h0000);

    // Bus error: single-cycle pulse is sticky until read
    m68k_berr_n = 1'b0;
    @(negedge c200m);
    m68k_berr_n = 1'b1;
    pi_read(rv);
    check("berr.read1", rv, 16'h0001);
    pi_read(rv);
    check("berr.read2", rv, 16'h0000);

    // Bus error exactly in the read-capture cycle survives the clear
    pi_a  = REG_STATUS;
    pi_rd = 1'b1;
    repeat (SYNC - 1) @(negedge c200m);
    m68k_berr_n = 1'b0;
    @(negedge c200m);
    m68k_berr_n = 1'b1;
    repeat (3) @(negedge c200m);
    check("berr.capture_read", pi_d_out, 16'h0000);
    pi_rd = 1'b0;
    repeat (SYNC + 1) @(negedge c200m);
    pi_read(rv);
    check("berr.after_capture", rv, 16'h0001);
    pi_read(rv);
    check("berr.cleared", rv, 16'h0000);

    // IPL readback
    m68k_ipl_n = 3'b101;
    pulse_c7m();
    pulse_c7m();
    check("ipl.zero_flag", {15'd0, pi_ipl_zero}, 16'd0);
    pi_read(rv);
    check("ipl.read", rv, 16'h4000);

    // One-sample IPL glitch
    m68k_ipl_n = 3'b111;
    pulse_c7m();
    m68k_ipl_n = 3'b101;
`ifdef PISTORM_IPL_FILTER_EN
    check("ipl.glitch_zero", {15'd0, pi_ipl_zero}, 16'd0);
    pi_read(rv);
    check("ipl.glitch_read", rv, 16'h4000);
`else
    check("ipl.glitch_zero", {15'd0, pi_ipl_zero}, 16'd1);
    pi_read(rv);
    check("ipl.glitch_read", rv, 16'h0000);
`endif
    pulse_c7m();
    pulse_c7m();
    check("ipl.restore_zero", {15'd0, pi_ipl_zero}, 16'd0);
    pi_read(rv);
    check("ipl.restore_read", rv, 16'h4000);

    // Reset in PENDING
    pi_write(REG_STATUS, 16'h0002);
    check("st.reset_out_low", {15'd0, reset_out}, 16'd0);
    check("st.status_q", status_q, 16'h0002);
    pi_write(REG_ADDR_HI, 16'h0000);
    wait_valid();
    reset_n = 1'b0;
    @(negedge c200m);
    check("mid_rst.valid", {15'd0, cmd_valid}, 16'd0);
    check("mid_rst.fc", {13'd0, cmd_fc}, 16'h0007);
    check("mid_rst.reset_out", {15'd0, reset_out}, 16'd1);
    check("mid_rst.txn", {15'd0, pi_txn_in_progress}, 16'd0);
    check("mid_rst.pi_d_out", pi_d_out, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge c200m);
    check("post_rst.valid", {15'd0, cmd_valid}, 16'd0);
    pi_write(REG_STATUS, 16'h0002);
    check("post_rst.reset_out", {15'd0, reset_out}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
